// File: rtl/phase_reset_seq_if.sv
// Control and status bundle between the run harness and phase_reset_seq.
// The harness drives start/halt_req; the sequencer drives everything else.
interface phase_reset_seq_if #(
  parameter int NUM_PHASES = 2,
  parameter int CNT_W      = 16
);
  logic                  start;
  logic                  halt_req;
  logic [NUM_PHASES-1:0] phase_en;
  logic [3:0]            phase_idx;
  logic                  core_rst_n;
  logic                  running;
  logic                  done;
  logic [CNT_W-1:0]      cycle_cnt;

  modport master (
    output start, halt_req,
    input  phase_en, phase_idx, core_rst_n, running, done, cycle_cnt
  );

  modport slave (
    input  start, halt_req,
    output phase_en, phase_idx, core_rst_n, running, done, cycle_cnt
  );
endinterface

// File: rtl/phase_reset_seq.sv
// Run controller: sequences core reset, emits non-overlapping phase enables,
// counts RUN cycles and stops on a cycle limit or an external halt.
module phase_reset_seq #(
  parameter int NUM_PHASES = 2,
  parameter int PHASE_HIGH = 4,
  parameter int PHASE_GAP  = 1,
  parameter int RST_HOLD   = 2,
  parameter int RUN_LIMIT  = 300,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             rst,
  phase_reset_seq_if.slave bus
);

  localparam int PERIOD = PHASE_HIGH + PHASE_GAP;
  localparam int SLOT_W = $clog2(PERIOD + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(PERIOD - 1);
  localparam logic [SLOT_W-1:0]     SLOT_HIGH = SLOT_W'(PHASE_HIGH);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [3:0]            IDX_LAST  = 4'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(RUN_LIMIT - 1);
  localparam logic [NUM_PHASES-1:0] PH_ONE    = NUM_PHASES'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state_q,   state_n;
  logic [HOLD_W-1:0]     hold_q,    hold_n;
  logic [SLOT_W-1:0]     slot_q,    slot_n;
  logic [3:0]            idx_q,     idx_n;
  logic [CNT_W-1:0]      cnt_q,     cnt_n;
  logic [NUM_PHASES-1:0] en_q,      en_n;
  logic                  crst_q,    crst_n;
  logic                  run_q,     run_n;
  logic                  done_q,    done_n;

  // Next-state and next-output are formed together so every output is a flop.
  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    slot_n  = slot_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    en_n    = '0;
    crst_n  = 1'b0;
    run_n   = 1'b0;
    done_n  = 1'b0;

    case (state_q)
      S_IDLE: begin
        hold_n = '0;
        slot_n = '0;
        idx_n  = '0;
        cnt_n  = '0;
        if (bus.start) state_n = S_HOLD;
      end

      S_HOLD: begin
        slot_n = '0;
        idx_n  = '0;
        cnt_n  = '0;
        if (bus.halt_req) begin
          state_n = S_IDLE;
          hold_n  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_n = S_RUN;
          hold_n  = '0;
          en_n    = PH_ONE;
          crst_n  = 1'b1;
          run_n   = 1'b1;
        end else begin
          hold_n = hold_q + HOLD_W'(1);
        end
      end

      S_RUN: begin
        crst_n = 1'b1;
        // Halt and limit share one exit path, so a coincident pair enters DONE once.
        if (bus.halt_req || (cnt_q == CNT_LAST)) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          run_n = 1'b1;
          cnt_n = cnt_q + CNT_W'(1);
          if (slot_q == SLOT_LAST) begin
            slot_n = '0;
            idx_n  = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
          end else begin
            slot_n = slot_q + SLOT_W'(1);
          end
          en_n = (slot_n < SLOT_HIGH) ? (PH_ONE << idx_n) : '0;
        end
      end

      S_DONE: begin
        if (bus.start) begin
          state_n = S_HOLD;
          hold_n  = '0;
          slot_n  = '0;
          idx_n   = '0;
          cnt_n   = '0;
        end else begin
          crst_n = 1'b1;
          done_n = 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        hold_n  = '0;
        slot_n  = '0;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      slot_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      crst_q  <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      hold_q  <= hold_n;
      slot_q  <= slot_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      en_q    <= en_n;
      crst_q  <= crst_n;
      run_q   <= run_n;
      done_q  <= done_n;
    end
  end

  assign bus.phase_en   = en_q;
  assign bus.phase_idx  = idx_q;
  assign bus.core_rst_n = crst_q;
  assign bus.running    = run_q;
  assign bus.done       = done_q;
  assign bus.cycle_cnt  = cnt_q;

endmodule
